// File: rtl/if_fetch_unit_pkg.sv
// ============================================================================
// if_fetch_unit_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the RV32I instruction-fetch stage:
//   - reset PC and NOP instruction defaults
//   - fetch state machine encodings (2-bit, kept as plain constants so the
//     encodings match older code that compares raw state values)
//   - major opcode constants also used by the immediate generator
//   - the {inst, pc} pair that moves through the output buffer
//   - small PC helper functions
// ============================================================================
package if_fetch_unit_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;   // addi x0,x0,0

    // Fetch state machine encodings
    localparam logic [1:0] S_REQ  = 2'b00;   // presenting a request to imem
    localparam logic [1:0] S_WAIT = 2'b01;   // request accepted, waiting for data
    localparam logic [1:0] S_HOLD = 2'b10;   // data parked in the hold register
    localparam logic [1:0] S_DROP = 2'b11;   // outstanding response is stale

    // RV32I major opcodes
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // One fetched instruction together with the address it came from
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_pair_t;

    // Instructions are word aligned, so the low two address bits are dropped
    function automatic logic [31:0] alignPc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Sequential PC; wraps naturally at 2^32
    function automatic logic [31:0] nextPc(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_unit_skid_buf.sv
// ============================================================================
// if_skid_buf
// ----------------------------------------------------------------------------
// Output side of the fetch stage: the register pair seen by ID plus a single
// hold register used when a memory response lands while ID is stalled.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   i_flush        drop both the output entry and the hold entry
//   i_load         write i_data straight into the output registers
//   i_capture      park i_data in the hold register
//   i_release      move the hold register into the output registers
//   i_data         incoming {inst, pc}
//   i_id_ready     ID consumes the output entry when it is valid
//   o_id_valid     output entry valid
//   o_id_inst      instruction to ID (NOP whenever o_id_valid is low)
//   o_id_pc        PC of o_id_inst
//   o_slot_free    output registers can accept a new entry this cycle
// ============================================================================
module if_skid_buf
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic        i_load,
    input  logic        i_capture,
    input  logic        i_release,
    input  fetch_pair_t i_data,
    input  logic        i_id_ready,
    output logic        o_id_valid,
    output logic [31:0] o_id_inst,
    output logic [31:0] o_id_pc,
    output logic        o_slot_free
);

    logic        r_outValid;
    logic [31:0] r_outInst;
    logic [31:0] r_outPc;
    logic        r_holdValid;
    logic [31:0] r_holdInst;
    logic [31:0] r_holdPc;

    // Output and hold registers. Flush wins over everything; a direct load
    // and a release are mutually exclusive by construction of the fetch FSM.
    // A release is only honoured when the hold register actually has data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outValid  <= 1'b0;
            r_outInst   <= NOP_INST;
            r_outPc     <= 32'h0000_0000;
            r_holdValid <= 1'b0;
            r_holdInst  <= NOP_INST;
            r_holdPc    <= 32'h0000_0000;
        end else if (i_flush) begin
            r_outValid  <= 1'b0;
            r_holdValid <= 1'b0;
        end else begin
            if (i_load) begin
                r_outValid <= 1'b1;
                r_outInst  <= i_data.inst;
                r_outPc    <= i_data.pc;
            end else if (i_release && r_holdValid) begin
                r_outValid  <= 1'b1;
                r_outInst   <= r_holdInst;
                r_outPc     <= r_holdPc;
                r_holdValid <= 1'b0;
            end else if (r_outValid && i_id_ready) begin
                r_outValid <= 1'b0;
            end

            if (i_capture) begin
                r_holdValid <= 1'b1;
                r_holdInst  <= i_data.inst;
                r_holdPc    <= i_data.pc;
            end
        end
    end

    assign o_id_valid  = r_outValid;
    assign o_id_inst   = r_outValid ? r_outInst : NOP_INST;
    assign o_id_pc     = r_outPc;
    assign o_slot_free = !r_outValid || i_id_ready;

endmodule

// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit
// ----------------------------------------------------------------------------
// Instruction-fetch stage of the single-issue RV32I core. Owns the PC, keeps
// at most one request outstanding on the instruction memory interface and
// hands {inst, pc, valid} to ID through if_skid_buf. Redirects from EX flush
// everything in flight and restart fetch at the new target.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   redirect_valid   EX taken branch/jump (highest priority)
//   redirect_pc      redirect target, low two bits ignored
//   imem_req         fetch request valid
//   imem_addr        fetch address (always the current PC)
//   imem_ready       memory accepts when imem_req & imem_ready
//   imem_rvalid      one read response per accepted request
//   imem_rdata       instruction word of the response
//   id_valid         id_inst/id_pc valid
//   id_inst          instruction to ID (NOP when id_valid is low)
//   id_pc            PC of id_inst
//   id_ready         ID consumes when id_valid & id_ready
// ============================================================================
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    input  logic        id_ready
);

    logic [1:0]  r_state;
    logic [31:0] r_pc;

    logic [1:0]  w_nextState;
    logic [31:0] w_nextPc;
    logic        w_req;
    logic        w_accept;
    logic        w_flush;
    logic        w_load;
    logic        w_capture;
    logic        w_release;
    logic        w_slotFree;
    fetch_pair_t w_fetchData;

    // The request is gated with rst_n so nothing is offered to memory while
    // the stage is held in reset, even though the state already reads S_REQ.
    assign w_req       = rst_n && (r_state == S_REQ);
    assign w_accept    = w_req && imem_ready;
    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign w_fetchData = '{inst: imem_rdata, pc: r_pc};

    // Next-state / next-PC logic. A redirect overrides every other event in
    // the same cycle. When a request is still outstanding after a redirect
    // the FSM parks in S_DROP so that the stale response is swallowed rather
    // than mistaken for data from the new target. A redirect arriving in
    // S_DROP retargets the PC but must keep waiting for the old response,
    // unless that response shows up in the same cycle.
    always_comb begin
        w_nextState = r_state;
        w_nextPc    = r_pc;
        w_flush     = 1'b0;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;

        if (redirect_valid) begin
            w_flush  = 1'b1;
            w_nextPc = alignPc(redirect_pc);
            case (r_state)
                S_REQ:   w_nextState = w_accept    ? S_DROP : S_REQ;
                S_WAIT:  w_nextState = imem_rvalid ? S_REQ  : S_DROP;
                S_HOLD:  w_nextState = S_REQ;
                S_DROP:  w_nextState = imem_rvalid ? S_REQ  : S_DROP;
                default: w_nextState = S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_accept) begin
                        w_nextState = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (w_slotFree) begin
                            w_load      = 1'b1;
                            w_nextPc    = nextPc(r_pc);
                            w_nextState = S_REQ;
                        end else begin
                            w_capture   = 1'b1;
                            w_nextState = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (id_ready) begin
                        w_release   = 1'b1;
                        w_nextPc    = nextPc(r_pc);
                        w_nextState = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        w_nextState = S_REQ;
                    end
                end
                default: w_nextState = S_REQ;
            endcase
        end
    end

    // State and PC registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_nextState;
            r_pc    <= w_nextPc;
        end
    end

    if_skid_buf #(
        .NOP_INST (NOP_INST)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (w_flush),
        .i_load      (w_load),
        .i_capture   (w_capture),
        .i_release   (w_release),
        .i_data      (w_fetchData),
        .i_id_ready  (id_ready),
        .o_id_valid  (id_valid),
        .o_id_inst   (id_inst),
        .o_id_pc     (id_pc),
        .o_slot_free (w_slotFree)
    );

endmodule
